aes_inv_round_ctrl: RTL and testbench

//  Sequences one AES-128 block decryption over the inverse-round datapath.

---
 rtl/aes_inv_round_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl
//   Sequences one AES block decryption over an iterative inverse-round
//   datapath, one round per clock: initial AddRoundKey, NR-1 full inverse
//   rounds (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), then a
//   final round without InvMixColumns. Round keys are fetched from an
//   external key store addressed by rk_idx and returned on rk_in in the
//   same cycle.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   clear      in   1    synchronous abort back to IDLE
//   in_valid   in   1    ct_in valid
//   in_ready   out  1    block accepts ct_in (IDLE only)
//   ct_in      in   128  ciphertext, byte 0 = [127:120]
//   rk_idx     out  4    round-key index requested this cycle
//   rk_in      in   128  round key for rk_idx (same cycle)
//   out_valid  out  1    pt_out valid (DONE)
//   out_ready  in   1    downstream accepts pt_out
//   pt_out     out  128  plaintext (state register)
//   busy       out  1    high in ROUND, FINAL and DONE
//
// Also contains the combinational GF(2^8) helpers aes_inv_sbox and
// aes_inv_mixcol.
// ---------------------------------------------------------------------------

// Inverse S-box: inverse affine transform followed by multiplicative
// inverse in GF(2^8), computed as x^254 (maps 0 to 0 naturally).
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  logic [7:0] w_a, w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60;
  logic [7:0] w_x120, w_x240, w_x252;

  assign w_a    = rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ 8'h05;
  // Addition chain 2,3,6,12,15,30,60,120,240,252,254
  assign w_x2   = gf_mul(w_a, w_a);
  assign w_x3   = gf_mul(w_x2, w_a);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x15  = gf_mul(w_x12, w_x3);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign o_byte = gf_mul(w_x252, w_x2);
endmodule

// InvMixColumns on one 32-bit column (byte 0 in [31:24]).
module aes_inv_mixcol (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a [4];
  logic [7:0] w_9 [4];
  logic [7:0] w_b [4];
  logic [7:0] w_d [4];
  logic [7:0] w_e [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mul
    logic [7:0] w_2, w_4, w_8;
    assign w_a[gi] = i_col[31-8*gi -: 8];
    assign w_2     = xt(w_a[gi]);
    assign w_4     = xt(w_2);
    assign w_8     = xt(w_4);
    assign w_9[gi] = w_8 ^ w_a[gi];
    assign w_b[gi] = w_8 ^ w_2 ^ w_a[gi];
    assign w_d[gi] = w_8 ^ w_4 ^ w_a[gi];
    assign w_e[gi] = w_8 ^ w_4 ^ w_2;
  end

  assign o_col[31:24] = w_e[0] ^ w_b[1] ^ w_d[2] ^ w_9[3];
  assign o_col[23:16] = w_9[0] ^ w_e[1] ^ w_b[2] ^ w_d[3];
  assign o_col[15:8]  = w_d[0] ^ w_9[1] ^ w_e[2] ^ w_b[3];
  assign o_col[7:0]   = w_b[0] ^ w_d[1] ^ w_9[2] ^ w_e[3];
endmodule

module aes_inv_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

  fsm_t         r_fsm, w_fsm_next;
  logic [3:0]   r_rnd, w_rnd_next;
  logic [127:0] r_state, w_state_next;

  logic [127:0] w_shift, w_sub, w_ark, w_mix;

  // InvShiftRows: row r rotates right by r columns, so output (r,c)
  // takes input (r, c-r mod 4). Each byte then feeds its own S-box.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int SRC = 4 * (((gi / 4) - (gi % 4) + 4) % 4) + (gi % 4);
    assign w_shift[127-8*gi -: 8] = r_state[127-8*SRC -: 8];
    aes_inv_sbox u_sbox (
      .i_byte (w_shift[127-8*gi -: 8]),
      .o_byte (w_sub[127-8*gi -: 8])
    );
  end

  assign w_ark = w_sub ^ rk_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    aes_inv_mixcol u_mix (
      .i_col (w_ark[127-32*gi -: 32]),
      .o_col (w_mix[127-32*gi -: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_rnd   <= 4'd0;
      r_state <= 128'd0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_rnd   <= w_rnd_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_fsm_next   = r_fsm;
    w_rnd_next   = r_rnd;
    w_state_next = r_state;
    rk_idx       = 4'(NR);
    unique case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = ct_in ^ rk_in;
          w_rnd_next   = 4'(NR - 1);
          w_fsm_next   = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx       = r_rnd;
        w_state_next = w_mix;
        if (r_rnd == 4'd1) w_fsm_next = S_FINAL;
        else               w_rnd_next = r_rnd - 4'd1;
      end
      S_FINAL: begin
        rk_idx       = 4'd0;
        w_state_next = w_ark;
        w_fsm_next   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_fsm_next = S_IDLE;
      end
      default: w_fsm_next = S_IDLE;
    endcase
    // Abort wins over everything; the state register is deliberately left
    // holding whatever partial value it had.
    if (clear) begin
      w_fsm_next   = S_IDLE;
      w_rnd_next   = 4'd0;
      w_state_next = r_state;
    end
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign pt_out    = r_state;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_round_ctrl
//   Directed bench for aes_inv_round_ctrl. A forward AES-128 model (S-box
//   built from GF(2^8) inversion by search, key expansion, encryption)
//   supplies the key store and produces ciphertexts for chosen plaintexts.
//   Expected plaintexts are queued when a block is driven and compared
//   when the output handshake occurs.
// ---------------------------------------------------------------------------
module tb_aes_inv_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ct_in, rk_in, pt_out;
  logic [3:0]   rk_idx;

  logic [127:0] rk_tab [0:15];
  logic [7:0]   sb [0:255];
  logic [31:0]  kw [0:43];
  logic [127:0] exp_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Key-store model: combinational lookup of the requested round key.
  assign rk_in = rk_tab[rk_idx];

  aes_inv_round_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sb[v[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        if (r < NR) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
        end
      end
      for (int b = 0; b < 16; b++) v[127-8*b -: 8] = s[b];
      v = v ^ rk_tab[r];
    end
    return v;
  endfunction

  // Scoreboard: one compare per completed output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("sb_expected_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("sb_plaintext", pt_out, exp_q.pop_front());
    end
  end

  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int cyc;
    ct_in = ct; in_valid = 1'b1; exp_q.push_back(pt);
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    check({tag, "_done"}, 128'(out_valid), 128'd1);
    step();
  endtask

  initial begin
    logic [127:0] pt2, ct2, pta, cta, ptb, ctb, pt3, ct3;
    logic [31:0]  tmp;
    logic [7:0]   rc, inv;
    int cyc, acc;
    int acc_t [2];
    bit pushed_b;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ct_in = '0;

    // Forward S-box and AES-128 key expansion for the bench model.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) kw[i] = C1_KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = kw[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      kw[i] = kw[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]} : 128'd0;

    // Reset values
    #2;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_rk_idx",    128'(rk_idx),    128'd10);
    check("rst_pt_out",    pt_out,          128'd0);
    step(); step();
    rst_n = 1'b1;

    // 1+2: FIPS-197 C.1, latency and rk_idx trace
    ct_in = C1_CT; in_valid = 1'b1; exp_q.push_back(C1_PT);
    check("t1_in_ready", 128'(in_ready), 128'd1);
    check("t2_rk_idx_accept", 128'(rk_idx), 128'd10);
    cyc = 0;
    do begin
      step(); cyc++;
      if (cyc == 1) in_valid = 1'b0;
      if (cyc <= NR) begin
        check("t2_rk_idx", 128'(rk_idx), 128'(NR - cyc));
        check("t1_busy", 128'(busy), 128'd1);
      end
    end while (out_valid !== 1'b1 && cyc < 40);
    check("t1_latency", 128'(cyc), 128'(NR + 1));
    step();
    check("t1_back_idle", 128'(in_ready), 128'd1);

    // 3: backpressure in DONE
    pt2 = 128'h0123456789abcdeffedcba9876543210;
    ct2 = enc(pt2);
    out_ready = 1'b0;
    ct_in = ct2; in_valid = 1'b1; exp_q.push_back(pt2);
    step(); in_valid = 1'b0; cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    check("t3_reached_done", 128'(out_valid), 128'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      check("t3_out_valid_held", 128'(out_valid), 128'd1);
      check("t3_pt_stable", pt_out, pt2);
      check("t3_in_ready_low", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("t3_release_in_ready", 128'(in_ready), 128'd1);
    check("t3_release_out_valid", 128'(out_valid), 128'd0);

    // 4: back-to-back with in_valid held high
    pta = {$urandom(), $urandom(), $urandom(), $urandom()};
    ptb = {$urandom(), $urandom(), $urandom(), $urandom()};
    cta = enc(pta); ctb = enc(ptb);
    ct_in = cta; in_valid = 1'b1; exp_q.push_back(pta);
    acc = 0; cyc = 0; pushed_b = 1'b0;
    while (acc < 2 && cyc < 80) begin
      if (in_ready === 1'b1 && in_valid === 1'b1) begin acc_t[acc] = cyc; acc++; end
      step(); cyc++;
      if (acc == 1 && !pushed_b) begin ct_in = ctb; exp_q.push_back(ptb); pushed_b = 1'b1; end
      if (acc == 2) in_valid = 1'b0;
    end
    check("t4_two_accepts", 128'(acc), 128'd2);
    check("t4_accept_spacing", 128'(acc_t[1] - acc_t[0]), 128'(NR + 2));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin step(); cyc++; end
    check("t4_drained", 128'(exp_q.size()), 128'd0);
    step();

    // 5: clear at rnd=5, then a clean decrypt
    pt3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct3 = enc(pt3);
    ct_in = ct3; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    repeat (4) step();
    check("t5_rk_idx_rnd5", 128'(rk_idx), 128'd5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clear_in_ready", 128'(in_ready), 128'd1);
    check("t5_clear_busy", 128'(busy), 128'd0);
    check("t5_clear_rk_idx", 128'(rk_idx), 128'd10);
    for (int i = 0; i < 12; i++) begin
      step();
      check("t5_no_out_valid", 128'(out_valid), 128'd0);
    end
    run_block(ct3, pt3, "t5_after_clear");

    // 6: asynchronous reset mid-ROUND, then recovery
    ct_in = C1_CT; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready",  128'(in_ready),  128'd1);
    check("t6_rst_out_valid", 128'(out_valid), 128'd0);
    check("t6_rst_busy",      128'(busy),      128'd0);
    check("t6_rst_rk_idx",    128'(rk_idx),    128'd10);
    check("t6_rst_pt_out",    pt_out,          128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_block(C1_CT, C1_PT, "t6_recovery");
    step();
    check("final_scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
